rsc_encoder_term: RTL

Parametrised recursive systematic convolutional (RSC) constituent encoder for the turbo encoder datapath. It encodes one framed block of `blk_len` information bits, then appends trellis-termination tail bits that drive the shift register back to the all-zero state. Generator polynomials and memory depth are parameters. The block uses valid/ready handshakes on both sides, so it can sit between the interleaver read port and the puncturing/output stage.

---
 rtl/turbo_pkg.sv | 27 ++
 rtl/rsc_trellis_step.sv | 47 ++++
 rtl/rsc_encoder_term.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/turbo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turbo_pkg
// Description : Shared types and constants for the turbo encoder datapath:
//               RSC encoder FSM state encoding, default LTE constituent
//               polynomials and block-length field sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package turbo_pkg;

  // Encoder control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } rsc_state_e;

  // LTE constituent code: g0 = 1+D^2+D^3 (feedback), g1 = 1+D+D^3 (feedforward)
  localparam logic [3:0] G0_LTE      = 4'b1101;
  localparam logic [3:0] G1_LTE      = 4'b1011;

  // Block-length field width and the largest block it can describe
  localparam int         K_W_DEFAULT = 13;
  localparam int         BLK_LEN_MAX = (1 << K_W_DEFAULT) - 1;

endpackage
`default_nettype wire

// File: rtl/rsc_trellis_step.sv
`default_nettype none
// ============================================================================
// Module      : rsc_trellis_step
// Description : One combinational trellis step of a recursive systematic
//               convolutional code. In termination mode the feedback is
//               cancelled so a zero is shifted in and the emitted systematic
//               bit is the cancelling tail bit.
// Ports       : i_s      - current shift register, bit k-1 holds stage s[k]
//               i_u      - information bit (ignored when i_term=1)
//               i_term   - termination step
//               o_a      - value shifted into stage s[1]
//               o_xk     - systematic / tail bit
//               o_zk     - parity bit
//               o_s_next - next shift-register contents
// Revision    : 1.0 - initial release
// ============================================================================
module rsc_trellis_step #(
  parameter int             MEM     = 3,
  parameter logic [MEM:0]   FB_POLY = 4'b1101,
  parameter logic [MEM:0]   FF_POLY = 4'b1011
) (
  input  logic [MEM-1:0] i_s,
  input  logic           i_u,
  input  logic           i_term,
  output logic           o_a,
  output logic           o_xk,
  output logic           o_zk,
  output logic [MEM-1:0] o_s_next
);

  logic w_fb;   // feedback tap sum over s[1..MEM]
  logic w_ff;   // feedforward tap sum over s[1..MEM]
  logic w_a;

  // Polynomial bit k pairs with stage s[k], i.e. i_s[k-1]
  assign w_fb = ^(FB_POLY[MEM:1] & i_s);
  assign w_ff = ^(FF_POLY[MEM:1] & i_s);

  // Tail bit equals the feedback sum, which forces the register input to 0
  assign w_a      = i_term ? 1'b0 : (i_u ^ w_fb);
  assign o_a      = w_a;
  assign o_xk     = i_term ? w_fb : i_u;
  assign o_zk     = (FF_POLY[0] & w_a) ^ w_ff;
  assign o_s_next = {i_s[MEM-2:0], w_a};

endmodule
`default_nettype wire

// File: rtl/rsc_encoder_term.sv
`default_nettype none
// ============================================================================
// Module      : rsc_encoder_term
// Description : Terminated RSC constituent encoder. Encodes blk_len
//               information bits, then emits MEM tail symbols returning the
//               shift register to zero. Valid/ready on input and output with
//               a single registered output stage.
// Ports       : clk, clr             - clock, synchronous active-high reset
//               start, blk_len       - block start strobe and length (IDLE only)
//               in_valid/in_ready, u - information bit handshake
//               out_valid/out_ready  - output symbol handshake
//               xk, zk, tail, last   - systematic, parity, tail flag, final flag
//               busy                 - block in progress or output pending
// Revision    : 1.0 - initial release
// ============================================================================
module rsc_encoder_term
  import turbo_pkg::*;
#(
  parameter int           MEM     = 3,
  parameter logic [MEM:0] FB_POLY = G0_LTE,
  parameter logic [MEM:0] FF_POLY = G1_LTE,
  parameter int           K_W     = K_W_DEFAULT
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [K_W-1:0] blk_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           u,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           xk,
  output logic           zk,
  output logic           tail,
  output logic           last,
  output logic           busy
);

  localparam logic [K_W-1:0] c_TAIL_LAST = K_W'(MEM - 1);
  localparam logic [K_W-1:0] c_ONE       = K_W'(1);

  rsc_state_e     r_state;
  logic [MEM-1:0] r_s;
  logic [K_W-1:0] r_len;
  logic [K_W-1:0] r_cnt;
  logic           r_out_valid;
  logic           r_xk;
  logic           r_zk;
  logic           r_tail;
  logic           r_last;

  logic           w_adv;
  logic           w_term;
  logic [K_W-1:0] w_cnt_inc;
  logic           w_tail_end;
  logic           w_a;
  logic           w_xk;
  logic           w_zk;
  logic [MEM-1:0] w_s_next;

  // Output register can take a new symbol when empty or being drained
  assign w_adv      = !r_out_valid || out_ready;
  assign w_term     = (r_state == ST_TAIL);
  assign w_cnt_inc  = r_cnt + c_ONE;
  assign w_tail_end = (r_cnt == c_TAIL_LAST);

  rsc_trellis_step #(
    .MEM     (MEM),
    .FB_POLY (FB_POLY),
    .FF_POLY (FF_POLY)
  ) u_step (
    .i_s      (r_s),
    .i_u      (u),
    .i_term   (w_term),
    .o_a      (w_a),
    .o_xk     (w_xk),
    .o_zk     (w_zk),
    .o_s_next (w_s_next)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_xk        <= 1'b0;
      r_zk        <= 1'b0;
      r_tail      <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      // Consumed symbol leaves the register unless replaced below
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (start && (blk_len != '0)) begin
            r_len   <= blk_len;
            r_s     <= '0;
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (in_valid && w_adv) begin
            r_s         <= w_s_next;
            r_xk        <= w_xk;
            r_zk        <= w_zk;
            r_tail      <= 1'b0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b1;
            if (w_cnt_inc == r_len) begin
              r_cnt   <= '0;
              r_state <= ST_TAIL;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        ST_TAIL: begin
          if (w_adv) begin
            r_s         <= w_s_next;
            r_xk        <= w_xk;
            r_zk        <= w_zk;
            r_tail      <= 1'b1;
            r_last      <= w_tail_end;
            r_out_valid <= 1'b1;
            if (w_tail_end) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_DATA) && w_adv;
  assign out_valid = r_out_valid;
  assign xk        = r_xk;
  assign zk        = r_zk;
  assign tail      = r_tail;
  assign last      = r_last;
  assign busy      = (r_state != ST_IDLE) || r_out_valid;

endmodule
`default_nettype wire
